// File: rtl/usb_uart_bridge_if.sv
// CDC byte-stream bundle between the USB CDC core (master) and the UART bridge (slave).
interface usb_uart_bridge_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output out_data, out_valid, in_ready,
                  input  out_ready, in_data, in_valid);
  modport slave  (input  out_data, out_valid, in_ready,
                  output out_ready, in_data, in_valid);
endinterface

// File: rtl/usb_uart_bridge.sv
// USB CDC to 8N1 UART bridge: OUT bytes are serialized on uart_tx_o,
// received UART bytes are buffered in a small FIFO and presented as the IN stream.
module usb_uart_bridge #(
  parameter int unsigned BAUD_DIV   = 'd417,
  parameter int unsigned RX_FIFO_AW = 'd2
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               configured_i,
  usb_uart_bridge_if.slave   cdc,
  output logic               uart_tx_o,
  input  logic               uart_rx_i,
  output logic               rx_overrun_o,
  output logic               frame_err_o
);

  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 1 << RX_FIFO_AW;
  localparam int unsigned CNTW  = RX_FIFO_AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------- TX ----------------
  logic [1:0]    tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [7:0]    tx_sh, tx_sh_d;
  logic          tx_q, tx_d;
  logic          tx_exp;

  assign tx_exp        = (tx_cnt == CW'(1));
  assign cdc.out_ready = (tx_state == S_IDLE) & configured_i;
  assign uart_tx_o     = tx_q;

  // Bit-period counter counts down from BAUD_DIV; expiry when it reaches 1.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_d       = tx_q;
    if (tx_state != S_IDLE && !tx_exp) tx_cnt_d = tx_cnt - CW'(1);
    case (tx_state)
      S_IDLE: if (cdc.out_valid && cdc.out_ready) begin
        tx_state_d = S_START;
        tx_cnt_d   = CW'(BAUD_DIV);
        tx_sh_d    = cdc.out_data;
        tx_d       = 1'b0;
      end
      S_START: if (tx_exp) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = CW'(BAUD_DIV);
        tx_bit_d   = 3'd0;
        tx_d       = tx_sh[0];
      end
      S_DATA: if (tx_exp) begin
        tx_cnt_d = CW'(BAUD_DIV);
        if (tx_bit == 3'd7) begin
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d = tx_bit + 3'd1;
          tx_sh_d  = {1'b0, tx_sh[7:1]};
          tx_d     = tx_sh[1];
        end
      end
      S_STOP: if (tx_exp) tx_state_d = S_IDLE;
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_q     <= tx_d;
    end
  end

  // ---------------- RX ----------------
  logic          rx_meta, rx_s;
  logic [1:0]    rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic          rx_exp, push_c, ferr_c;

  assign rx_exp = (rx_cnt == CW'(1));

  // Start edge loads half a bit so every later sample lands mid-bit; STOP
  // returns to IDLE mid-bit so a back-to-back start edge is not missed.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    push_c     = 1'b0;
    ferr_c     = 1'b0;
    if (rx_state != S_IDLE && !rx_exp) rx_cnt_d = rx_cnt - CW'(1);
    case (rx_state)
      S_IDLE: if (!rx_s) begin
        rx_state_d = S_START;
        rx_cnt_d   = CW'(BAUD_DIV / 2);
      end
      S_START: if (rx_exp) begin
        if (rx_s) rx_state_d = S_IDLE;
        else begin
          rx_state_d = S_DATA;
          rx_cnt_d   = CW'(BAUD_DIV);
          rx_bit_d   = 3'd0;
        end
      end
      S_DATA: if (rx_exp) begin
        rx_sh_d  = {rx_s, rx_sh[7:1]};
        rx_cnt_d = CW'(BAUD_DIV);
        if (rx_bit == 3'd7) rx_state_d = S_STOP;
        else                rx_bit_d   = rx_bit + 3'd1;
      end
      S_STOP: if (rx_exp) begin
        rx_state_d = S_IDLE;
        if (rx_s) push_c = configured_i;
        else      ferr_c = configured_i;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_meta  <= uart_rx_i;
      rx_s     <= rx_meta;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]            mem [DEPTH];
  logic [RX_FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0]       count;
  logic                  pop_c, full_c, push_ok_c, overrun_c;

  assign cdc.in_valid = (count != '0);
  assign cdc.in_data  = mem[rd_ptr];
  assign pop_c        = cdc.in_valid & cdc.in_ready;
  assign full_c       = (count == CNTW'(DEPTH));
  assign push_ok_c    = push_c & (~full_c | pop_c);
  assign overrun_c    = push_c & full_c & ~pop_c;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_overrun_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_overrun_o <= overrun_c;
      frame_err_o  <= ferr_c;
      if (!configured_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok_c) begin
          mem[wr_ptr] <= rx_sh;
          wr_ptr      <= wr_ptr + RX_FIFO_AW'(1);
        end
        if (pop_c) rd_ptr <= rd_ptr + RX_FIFO_AW'(1);
        count <= count + CNTW'(push_ok_c) - CNTW'(pop_c);
      end
    end
  end

endmodule

// File: doc/usb_uart_bridge.md
Name: usb_uart_bridge

Overview:
- Application-side stage that sits directly on the CDC byte-stream ports. It consumes bytes the host sends on the bulk OUT endpoint and serializes them onto a UART TX line.
- UART RX bytes are deserialized into a small FIFO and presented as the bulk IN stream.
- Turns the USB CDC device into a USB-to-serial adapter; the bridge runs in the CDC clock domain.
- Line format fixed 8N1.

Parameters:
- BAUD_DIV, 'd417, clk_i cycles per UART bit (48 MHz / 115200); legal range 8..65535.
- RX_FIFO_AW, 'd2, RX FIFO address width; depth = 2**RX_FIFO_AW.

Ports:
- clk_i  input  1  sole clock, 12MHz*BIT_SAMPLES domain of the CDC core.
- rstn_i  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- configured_i  input  1  CDC core configured state.
- out_data_i  input  8  host->device byte from CDC.
- out_valid_i  input  1  out_data_i valid.
- out_ready_o  output  1  bridge accepts out_data_i.
- in_data_o  output  8  device->host byte to CDC.
- in_valid_o  output  1  in_data_o valid.
- in_ready_i  input  1  CDC accepts in_data_o.
- uart_tx_o  output  1  serial TX, idle high.
- uart_rx_i  input  1  serial RX, asynchronous.
- rx_overrun_o  output  1  1-cycle pulse: received byte dropped, FIFO full.
- frame_err_o  output  1  1-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset values:
  - uart_tx_o=1; out_ready_o=0; in_valid_o=0; in_data_o=0; rx_overrun_o=0; frame_err_o=0.
  - Both FSMs IDLE; FIFO empty; synchronizer flops=1.
- TX FSM (IDLE, START, DATA, STOP):
  - out_ready_o = (state==IDLE) & configured_i; combinational.
  - Handshake (out_valid_i & out_ready_o) latches byte and enters START the next cycle.
  - START drives 0 for BAUD_DIV cycles. DATA drives bits LSB first, BAUD_DIV cycles each, using a 3-bit counter. STOP drives 1 for BAUD_DIV cycles, then IDLE.
  - Frame length 10*BAUD_DIV cycles.
  - Handshake-to-next-out_ready_o = 10*BAUD_DIV+1 cycles.
  - configured_i falling mid-frame: current frame completes; no new accepts.
- RX synchronizer: 2-flop on uart_rx_i (rx_s). All RX logic uses rx_s.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: rx_s==0 -> START, with the baud counter loaded to BAUD_DIV/2 (integer floor).
  - START at count expiry: rx_s==1 -> IDLE (glitch, nothing reported); rx_s==0 -> DATA, counter = BAUD_DIV.
  - DATA: sample rx_s at each expiry into a shift register, LSB first; 8 samples -> STOP.
  - STOP at expiry: rx_s==1 -> push byte. rx_s==0 -> discard byte, pulse frame_err_o.
  - Either STOP outcome returns to IDLE mid-stop-bit, so a back-to-back start edge is detected.
- RX FIFO:
  - in_valid_o = ~empty; in_data_o = head entry; registered storage, no bypass.
  - Push-to-in_valid_o latency is 1 cycle.
  - Pop on in_valid_o & in_ready_i.
  - Push is accepted when count<DEPTH, or when a pop occurs the same cycle.
  - A push while full with no pop drops the byte and pulses rx_overrun_o. FIFO contents are unchanged.
  - Pointers wrap modulo DEPTH. Count is RX_FIFO_AW+1 bits.
  - Simultaneous push and pop on an empty FIFO: no pop (in_valid_o=0), push accepted.
- configured_i low:
  - FIFO is held empty (flushed); in_valid_o=0.
  - RX keeps framing, but completed bytes are discarded silently: no overrun, no frame_err pulse.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous); uart_tx_o goes high at once.

Test Plan:
1. Reset, BAUD_DIV=8, configured_i=1, push OUT byte 8'hA5 -> uart_tx_o shows 0,1,0,1,0,0,1,0,1,1, each held exactly 8 cycles; out_ready_o high again 81 cycles after handshake.
2. Drive RX frame 8'h3C at 8 cycles/bit, in_ready_i=1 -> in_valid_o high 1 cycle with in_data_o=8'h3C, no error pulses.
3. in_ready_i=0, send 5 RX bytes 01..05, RX_FIFO_AW=2 -> bytes 01..04 held; rx_overrun_o pulses once on byte 05. Raising in_ready_i then yields 01,02,03,04 in order.
4. RX frame 8'h55 with stop bit forced 0 -> frame_err_o pulses once, FIFO stays empty. A 3-cycle low glitch on uart_rx_i -> no byte, no pulses.
5. configured_i=0 while out_valid_i=1 -> out_ready_o stays 0, uart_tx_o stays 1; an RX byte arriving is dropped with no pulses.
6. Assert rstn_i low mid-TX frame (after 3 bits) -> uart_tx_o=1 immediately. After release, the next OUT byte 8'hFF transmits a clean full frame.
